// File: rtl/kitchen_timer_ctrl_if.sv
// rtl/kitchen_timer_ctrl_if.sv - button/tick/strobe bundle between timer controller and its neighbours
//
// Signals:
//   EN_1HZ, EN_2HZ        prescaler ticks, one CLK cycle wide
//   M_INPUT, S_INPUT      debounced minute/second set buttons, 1=pressed
//   START, CLR            debounced start/stop and clear buttons, 1=pressed
//   ZERO                  counter datapath reads 00:00
//   M_INC, S_INC, DEC     one-cycle strobes into the MM:SS counter
//   CNT_CLR               one-cycle strobe: counter to 00:00
//   RUN, ARM, STATE       controller status
// Modports:
//   master  environment side (drives buttons, ticks, ZERO)
//   slave   controller side
interface kitchen_timer_ctrl_if;
    logic       EN_1HZ;
    logic       EN_2HZ;
    logic       M_INPUT;
    logic       S_INPUT;
    logic       START;
    logic       CLR;
    logic       ZERO;
    logic       M_INC;
    logic       S_INC;
    logic       DEC;
    logic       CNT_CLR;
    logic       RUN;
    logic       ARM;
    logic [1:0] STATE;

    modport master (
        output EN_1HZ, EN_2HZ, M_INPUT, S_INPUT, START, CLR, ZERO,
        input  M_INC, S_INC, DEC, CNT_CLR, RUN, ARM, STATE
    );

    modport slave (
        input  EN_1HZ, EN_2HZ, M_INPUT, S_INPUT, START, CLR, ZERO,
        output M_INC, S_INC, DEC, CNT_CLR, RUN, ARM, STATE
    );
endinterface

// File: rtl/kitchen_timer_ctrl.sv
// rtl/kitchen_timer_ctrl.sv - kitchen timer set/run/pause/alarm control FSM
//
// Ports:
//   CLK   system clock
//   RES   synchronous active-low reset
//   bus   kitchen_timer_ctrl_if.slave: button levels, ticks and ZERO in;
//         M_INC/S_INC/DEC/CNT_CLR strobes, RUN, ARM and STATE out
// Parameters:
//   ALARM_SEC  EN_1HZ ticks ARM stays high before returning to SET (1..255)
//   RPT_DLY    EN_2HZ ticks a held M/S button waits before auto-repeat (1..15)
module kitchen_timer_ctrl #(
    parameter int unsigned ALARM_SEC = 10,
    parameter int unsigned RPT_DLY   = 2
) (
    input  logic                 CLK,
    input  logic                 RES,
    kitchen_timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] RPT_DLY_C   = 4'(RPT_DLY);
    localparam logic [7:0] ALARM_SEC_C = 8'(ALARM_SEC);

    state_t     state;

    logic       m_prev;
    logic       s_prev;
    logic       start_prev;
    logic       clr_prev;

    logic [3:0] m_rpt_cnt;
    logic [3:0] s_rpt_cnt;
    logic [7:0] alarm_cnt;

    logic       m_inc_q;
    logic       s_inc_q;
    logic       dec_q;
    logic       cnt_clr_q;

    logic       m_rise;
    logic       s_rise;
    logic       start_rise;
    logic       clr_rise;
    logic       set_mode;
    logic       s_active;
    logic       m_rpt_fire;
    logic       s_rpt_fire;
    logic       m_req;
    logic       s_req;

    assign m_rise     = bus.M_INPUT & ~m_prev;
    assign s_rise     = bus.S_INPUT & ~s_prev;
    assign start_rise = bus.START   & ~start_prev;
    assign clr_rise   = bus.CLR     & ~clr_prev;

    // SET and PAUSE share the same M/S adjust behaviour.
    assign set_mode   = (state == ST_SET) || (state == ST_PAUSE);

    // A held M button masks S entirely: no S edges and no S repeat
    // counting until M is let go.
    assign s_active   = bus.S_INPUT & ~bus.M_INPUT;

    // The repeat counter saturates at RPT_DLY; every tick seen while
    // saturated produces one increment.
    assign m_rpt_fire = bus.M_INPUT & bus.EN_2HZ & (m_rpt_cnt == RPT_DLY_C);
    assign s_rpt_fire = s_active    & bus.EN_2HZ & (s_rpt_cnt == RPT_DLY_C);

    assign m_req      = m_rise | m_rpt_fire;
    assign s_req      = s_active & (s_rise | s_rpt_fire);

    // Edge detectors; during reset they track the live level so a button
    // held through reset never looks like a fresh press.
    always_ff @(posedge CLK) begin
        m_prev     <= bus.M_INPUT;
        s_prev     <= bus.S_INPUT;
        start_prev <= bus.START;
        clr_prev   <= bus.CLR;
    end

    // Auto-repeat hold counters.
    always_ff @(posedge CLK) begin
        if (!RES) begin
            m_rpt_cnt <= 4'd0;
            s_rpt_cnt <= 4'd0;
        end else begin
            if (!set_mode || !bus.M_INPUT) begin
                m_rpt_cnt <= 4'd0;
            end else if (bus.EN_2HZ && (m_rpt_cnt != RPT_DLY_C)) begin
                m_rpt_cnt <= m_rpt_cnt + 4'd1;
            end

            // Held at zero while M masks S, so S restarts its delay from
            // scratch once M is released.
            if (!set_mode || !s_active) begin
                s_rpt_cnt <= 4'd0;
            end else if (bus.EN_2HZ && (s_rpt_cnt != RPT_DLY_C)) begin
                s_rpt_cnt <= s_rpt_cnt + 4'd1;
            end
        end
    end

    // Main FSM with registered strobes. Priority in every state:
    // CLR > START > M > S > timer ticks.
    always_ff @(posedge CLK) begin
        if (!RES) begin
            state     <= ST_SET;
            alarm_cnt <= 8'd0;
            m_inc_q   <= 1'b0;
            s_inc_q   <= 1'b0;
            dec_q     <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            m_inc_q   <= 1'b0;
            s_inc_q   <= 1'b0;
            dec_q     <= 1'b0;
            cnt_clr_q <= 1'b0;
            alarm_cnt <= 8'd0;

            unique case (state)
                ST_SET, ST_PAUSE: begin
                    if (clr_rise) begin
                        cnt_clr_q <= 1'b1;
                        state     <= ST_SET;
                    end else if (start_rise) begin
                        // Nothing to count down from 00:00, so stay put.
                        if (!bus.ZERO) begin
                            state <= ST_RUN;
                        end
                    end else if (m_req) begin
                        m_inc_q <= 1'b1;
                    end else if (s_req) begin
                        s_inc_q <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (clr_rise) begin
                        cnt_clr_q <= 1'b1;
                        state     <= ST_SET;
                    end else if (start_rise) begin
                        state <= ST_PAUSE;
                    end else if (bus.ZERO) begin
                        // Never decrement past 00:00.
                        state <= ST_ALARM;
                    end else if (bus.EN_1HZ) begin
                        dec_q <= 1'b1;
                    end
                end

                ST_ALARM: begin
                    if (clr_rise) begin
                        cnt_clr_q <= 1'b1;
                        state     <= ST_SET;
                    end else if (start_rise) begin
                        state <= ST_SET;
                    end else if (bus.EN_1HZ) begin
                        if ((alarm_cnt + 8'd1) == ALARM_SEC_C) begin
                            state <= ST_SET;
                        end else begin
                            alarm_cnt <= alarm_cnt + 8'd1;
                        end
                    end else begin
                        alarm_cnt <= alarm_cnt;
                    end
                end

                default: begin
                    state <= ST_SET;
                end
            endcase
        end
    end

    assign bus.M_INC   = m_inc_q;
    assign bus.S_INC   = s_inc_q;
    assign bus.DEC     = dec_q;
    assign bus.CNT_CLR = cnt_clr_q;
    assign bus.RUN     = (state == ST_RUN);
    assign bus.ARM     = (state == ST_ALARM);
    assign bus.STATE   = state;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// tb/tb_kitchen_timer_ctrl.sv - directed self-checking bench for kitchen_timer_ctrl
module tb_kitchen_timer_ctrl;

    logic CLK;
    logic RES;

    kitchen_timer_ctrl_if bus ();

    kitchen_timer_ctrl #(
        .ALARM_SEC (10),
        .RPT_DLY   (2)
    ) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    int m_inc_cnt   = 0;
    int s_inc_cnt   = 0;
    int dec_cnt     = 0;
    int cnt_clr_cnt = 0;
    int multi_cnt   = 0;

    // Strobes are one full cycle wide, so each is seen once at the falling edge.
    always @(negedge CLK) begin
        if (bus.M_INC)   m_inc_cnt++;
        if (bus.S_INC)   s_inc_cnt++;
        if (bus.DEC)     dec_cnt++;
        if (bus.CNT_CLR) cnt_clr_cnt++;
        if ((int'(bus.M_INC) + int'(bus.S_INC) + int'(bus.DEC) + int'(bus.CNT_CLR)) > 1)
            multi_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic tick1hz();
        bus.EN_1HZ = 1'b1;
        step();
        bus.EN_1HZ = 1'b0;
        step(2);
    endtask

    task automatic tick2hz();
        bus.EN_2HZ = 1'b1;
        step();
        bus.EN_2HZ = 1'b0;
        step(2);
    endtask

    task automatic press_start();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    int base_m, base_s, base_d, base_c;

    initial begin
        RES         = 1'b0;
        bus.EN_1HZ  = 1'b0;
        bus.EN_2HZ  = 1'b0;
        bus.M_INPUT = 1'b0;
        bus.S_INPUT = 1'b0;
        bus.START   = 1'b0;
        bus.CLR     = 1'b0;
        bus.ZERO    = 1'b0;
        step(3);

        check("rst_state", int'(bus.STATE), 0);
        check("rst_run",   int'(bus.RUN), 0);
        check("rst_arm",   int'(bus.ARM), 0);
        check("rst_strobes", int'(bus.M_INC) + int'(bus.S_INC) + int'(bus.DEC) + int'(bus.CNT_CLR), 0);
        RES = 1'b1;
        step(2);

        // Single M press held 3 cycles -> one M_INC, one cycle after the edge.
        base_m = m_inc_cnt;
        bus.M_INPUT = 1'b1;
        step();
        check("m_inc_latency", int'(bus.M_INC), 1);
        step(2);
        bus.M_INPUT = 1'b0;
        step(3);
        check("m_press_count", m_inc_cnt - base_m, 1);
        check("m_press_state", int'(bus.STATE), 0);

        // S held across 6 EN_2HZ ticks: press + repeats on ticks 3..6.
        base_s = s_inc_cnt;
        base_m = m_inc_cnt;
        bus.S_INPUT = 1'b1;
        step(2);
        for (int t = 0; t < 6; t++) tick2hz();
        bus.S_INPUT = 1'b0;
        step(3);
        check("s_repeat_count", s_inc_cnt - base_s, 5);
        check("s_repeat_no_m", m_inc_cnt - base_m, 0);

        // RUN and count down three seconds.
        base_d = dec_cnt;
        press_start();
        check("run_state", int'(bus.STATE), 1);
        check("run_flag",  int'(bus.RUN), 1);
        step(2);
        for (int t = 0; t < 3; t++) tick1hz();
        check("dec_count3", dec_cnt - base_d, 3);

        // START with the 4th tick: pause wins, no DEC.
        bus.START  = 1'b1;
        bus.EN_1HZ = 1'b1;
        step();
        bus.START  = 1'b0;
        bus.EN_1HZ = 1'b0;
        check("pause_state", int'(bus.STATE), 2);
        step(2);
        check("pause_no_dec", dec_cnt - base_d, 3);

        // Resume, then ZERO drives the alarm; coincident tick must not DEC.
        press_start();
        check("resume_state", int'(bus.STATE), 1);
        step(2);
        bus.ZERO   = 1'b1;
        bus.EN_1HZ = 1'b1;
        step();
        bus.EN_1HZ = 1'b0;
        check("alarm_state", int'(bus.STATE), 3);
        check("alarm_arm",   int'(bus.ARM), 1);
        step(2);
        check("alarm_no_dec", dec_cnt - base_d, 3);

        for (int t = 0; t < 9; t++) tick1hz();
        check("alarm_arm_tick9", int'(bus.ARM), 1);
        bus.EN_1HZ = 1'b1;
        step();
        bus.EN_1HZ = 1'b0;
        check("alarm_timeout_arm",   int'(bus.ARM), 0);
        check("alarm_timeout_state", int'(bus.STATE), 0);
        step(2);

        // START with ZERO=1 in SET does nothing.
        press_start();
        check("set_zero_start", int'(bus.STATE), 0);
        step(2);

        // Alarm again, cancelled by START coincident with tick 4.
        bus.ZERO = 1'b0;
        press_start();
        step(2);
        bus.ZERO = 1'b1;
        step(2);
        check("alarm2_arm", int'(bus.ARM), 1);
        for (int t = 0; t < 3; t++) tick1hz();
        bus.START  = 1'b1;
        bus.EN_1HZ = 1'b1;
        step();
        bus.START  = 1'b0;
        bus.EN_1HZ = 1'b0;
        check("alarm_cancel_arm",   int'(bus.ARM), 0);
        check("alarm_cancel_state", int'(bus.STATE), 0);
        step(2);

        // CLR in SET pulses CNT_CLR.
        base_c = cnt_clr_cnt;
        bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        check("clr_set_pulse", int'(bus.CNT_CLR), 1);
        step(2);
        check("clr_set_count", cnt_clr_cnt - base_c, 1);

        // M and S rising together: M only.
        bus.ZERO = 1'b0;
        base_m = m_inc_cnt;
        base_s = s_inc_cnt;
        bus.M_INPUT = 1'b1;
        bus.S_INPUT = 1'b1;
        step();
        check("ms_m_inc", int'(bus.M_INC), 1);
        check("ms_s_inc", int'(bus.S_INC), 0);
        bus.M_INPUT = 1'b0;
        bus.S_INPUT = 1'b0;
        step(3);
        check("ms_m_count", m_inc_cnt - base_m, 1);
        check("ms_s_count", s_inc_cnt - base_s, 0);

        // CLR in RUN returns to SET with CNT_CLR.
        press_start();
        step(2);
        check("run2_state", int'(bus.STATE), 1);
        base_c = cnt_clr_cnt;
        bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        check("clr_run_state", int'(bus.STATE), 0);
        check("clr_run_pulse", int'(bus.CNT_CLR), 1);
        step(2);

        // Reset mid-RUN with START held through it.
        bus.START = 1'b1;
        step();
        check("run3_flag", int'(bus.RUN), 1);
        step(2);
        RES = 1'b0;
        step();
        check("res_mid_run_state", int'(bus.STATE), 0);
        check("res_mid_run_flag",  int'(bus.RUN), 0);
        step(2);
        RES = 1'b1;
        step(3);
        check("start_held_reset", int'(bus.STATE), 0);
        bus.START = 1'b0;
        step(2);
        check("start_released", int'(bus.STATE), 0);

        check("one_strobe_max", multi_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
